// File: rtl/fifo_axis_reader_pkg.sv
// Shared types and defaults for the FIFO-to-AXI4-Stream video reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_axis_reader_pkg;

    localparam int DEF_LINE_WIDTH = 1920;
    localparam int DEF_LINE_COUNT = 1080;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fifo_axis_outbuf.sv
// Two-entry skid buffer between the FIFO read port and the AXI-Stream output.
// Latency: pushed word is visible at head_o the cycle after push_i.
// Backpressure: head_o holds until pop_i; a push into a full buffer lands only with a same-cycle pop.
module fifo_axis_outbuf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // Ring storage with independent read/write pointers; push and pop may coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_axis_reader.sv
// Pulls pixels from a show-ahead-less FIFO and emits an AXI4-Stream video frame (tuser=SOF, tlast=EOL).
// Latency: first tvalid two cycles after the first eligible pop; then one beat per cycle.
// Backpressure: tready low holds the beat; pops are throttled so buffered+in-flight never exceeds 2.
// Optional: define FIFO_AXIS_READER_UNDERRUN_EN to build the sticky mid-frame underrun detector.
module fifo_axis_reader
    import fifo_axis_reader_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int LINE_COUNT = DEF_LINE_COUNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fifo_dout,
    output logic        fifo_oe,
    input  logic        fifo_empty,
    input  logic        enable,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        frame_done,
    output logic        underrun
);

    localparam int TOTAL = LINE_WIDTH * LINE_COUNT;
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int XW    = clog2_min1(LINE_WIDTH);
    localparam int YW    = clog2_min1(LINE_COUNT);

    localparam logic [IW-1:0] TOTAL_W = IW'(TOTAL);
    localparam logic [XW-1:0] X_LAST  = XW'(LINE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(LINE_COUNT - 1);

    state_e          state_q;
    logic [IW-1:0]   issued_q;
    logic            inflight_q;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [1:0]      buf_count;
    logic [31:0]     buf_head;
    logic            beat_acc;
    logic            frame_end;
    logic [2:0]      occ_after;

    assign beat_acc  = m_axis_tvalid && m_axis_tready;
    assign frame_end = beat_acc && (x_q == X_LAST) && (y_q == Y_LAST);

    // Occupancy counts this cycle's pop as already gone, otherwise a full-rate
    // stream would stall every other cycle; the total still never exceeds 2.
    assign occ_after = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, beat_acc};
    assign fifo_oe   = (state_q == STREAM) && !fifo_empty &&
                       (issued_q < TOTAL_W) && (occ_after < 3'd2);

    // Frame FSM and per-frame issue counter; enable only matters at frame boundaries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            issued_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    issued_q <= '0;
                    if (enable) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (fifo_oe) begin
                        issued_q <= issued_q + 1'b1;
                    end
                    if (frame_end) begin
                        issued_q <= '0;
                        state_q  <= enable ? STREAM : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO data is valid the cycle after the pop; remember that a word is on the way
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_oe;
        end
    end

    // Next raster position after an accepted beat
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (beat_acc) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Raster position registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    fifo_axis_outbuf #(.W(32)) u_outbuf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .data_i  (fifo_dout),
        .pop_i   (beat_acc),
        .count_o (buf_count),
        .head_o  (buf_head)
    );

    assign m_axis_tvalid = (buf_count != 2'd0);
    assign m_axis_tdata  = buf_head;
    assign m_axis_tuser  = m_axis_tvalid && (x_q == '0) && (y_q == '0);
    assign m_axis_tlast  = m_axis_tvalid && (x_q == X_LAST);
    assign frame_done    = frame_end;

`ifdef FIFO_AXIS_READER_UNDERRUN_EN
    logic underrun_q;

    // Sticky: source ran dry mid-frame with nothing buffered or on the way
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_q <= 1'b0;
        end else if ((state_q == STREAM) && (issued_q != '0) && (issued_q != TOTAL_W) &&
                     (buf_count == 2'd0) && !inflight_q && fifo_empty) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

endmodule
